// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and its prefetch queue.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  // Canonical NOP (addi x0, x0, 0) presented when no instruction is buffered.
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_sync_fifo.sv
// Registered-storage synchronous FIFO with flush; head data comes straight from
// the storage flops, so there is no combinational path from push to pop_data.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && !flush && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && !flush && empty));

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with a DEPTH-entry prefetch queue; issues sequential word
// requests ahead of decode and discards in-flight responses made stale by a redirect.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN         = XLEN_DEFAULT,
  parameter int unsigned      DEPTH        = 4,
  parameter logic [XLEN-1:0]  RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_src,
  input  logic [XLEN-1:0] branch_target,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  localparam int unsigned     CW    = $clog2(DEPTH) + 1;
  localparam logic [XLEN-1:0] NOP_W = XLEN'(NOP);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     drop_q, drop_d;

  logic [CW-1:0]     q_count, trk_count;
  logic              q_full, q_empty, trk_full, trk_empty;
  logic [2*XLEN-1:0] q_head;
  logic [XLEN-1:0]   trk_head_pc;

  logic              credit_ok, req_fire, rsp_drop, q_push, q_pop;
  logic              unused_ok;

  // The tracking FIFO holds one PC per accepted request, so its occupancy is the in-flight count.
  assign credit_ok     = ({1'b0, trk_count} + {1'b0, q_count}) < (CW+1)'(DEPTH);
  assign mem_req_valid = rst_n & ~pc_src & credit_ok;
  assign mem_addr      = fetch_pc_q;
  assign req_fire      = mem_req_valid & mem_req_ready;

  assign rsp_drop      = pc_src | (drop_q != '0);
  assign q_push        = mem_rsp_valid & ~rsp_drop;
  assign instr_valid   = ~q_empty & ~pc_src;
  assign q_pop         = instr_valid & instr_ready;

  assign pc            = q_empty ? '0 : q_head[2*XLEN-1:XLEN];
  assign instr         = !rst_n ? '0 : (q_empty ? NOP_W : q_head[XLEN-1:0]);

  assign unused_ok     = ^{branch_target[1:0], trk_full};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_d     = drop_q;
    if (pc_src) begin
      fetch_pc_d = {branch_target[XLEN-1:2], 2'b00};
      // Every outstanding request predates this redirect (earlier discards included),
      // so the discard budget is exactly what remains in flight after this cycle.
      drop_d     = trk_count - CW'(mem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end
      if (mem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_VECTOR;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_q     <= drop_d;
    end
  end

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_instr_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (q_push),
    .push_data ({trk_head_pc, mem_rsp_data}),
    .pop       (q_pop),
    .flush     (pc_src),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Never flushed: stale entries leave one-for-one with their discarded responses.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_req_pc_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (req_fire),
    .push_data (fetch_pc_q),
    .pop       (mem_rsp_valid),
    .flush     (1'b0),
    .pop_data  (trk_head_pc),
    .full      (trk_full),
    .empty     (trk_empty),
    .count     (trk_count)
  );

  a_queue_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(q_push && q_full && !q_pop));
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_rsp_valid && trk_empty));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order memory model of configurable latency.
module tb_fetch_prefetch;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RV    = 32'h0000_0000;
  localparam logic [31:0] NOPV  = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic [31:0] instr;

  int checks = 0;
  int passed = 0;

  int unsigned ready_mode = 0;
  bit          lat_random = 0;
  int unsigned lat_fixed  = 1;
  int unsigned cyc        = 0;
  int unsigned last_due   = 0;
  logic [31:0] pend_addr[$];
  int unsigned pend_due[$];

  fetch_prefetch #(
    .XLEN         (XLEN),
    .DEPTH        (DEPTH),
    .RESET_VECTOR (RV)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc            (pc),
    .instr         (instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: drives ready and responses 2 time units after each rising edge.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        pend_addr.delete();
        pend_due.delete();
        last_due = 0;
      end
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(pend_addr[0]);
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
      end
      case (ready_mode)
        0:       mem_req_ready = 1'b1;
        1:       mem_req_ready = 1'($urandom_range(0, 1));
        default: mem_req_ready = 1'b0;
      endcase
    end
  end

  initial begin
    int unsigned lat;
    int unsigned due;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid && mem_req_ready) begin
        lat = lat_random ? $urandom_range(1, 5) : lat_fixed;
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(mem_addr);
        pend_due.push_back(due);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", passed, checks);
    $fatal(1);
  end

  task automatic do_reset();
    rst_n  = 1'b0;
    pc_src = 1'b0;
    branch_target = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pc_src = 1'b0; branch_target = '0; instr_ready = 1'b1;
    ready_mode = 0; lat_random = 0; lat_fixed = 1;
    repeat (2) @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL rst_instr_valid: got %b want 0", instr_valid); else passed++;
    checks++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h want 0", pc); else passed++;
    checks++; if (instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", instr); else passed++;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b1) $display("FAIL post_rst_req_valid: got %b want 1", mem_req_valid); else passed++;
    checks++; if (mem_addr !== RV) $display("FAIL post_rst_addr: got %h want %h", mem_addr, RV); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL post_rst_instr_valid: got %b want 0", instr_valid); else passed++;
    checks++; if (instr !== NOPV) $display("FAIL post_rst_nop: got %h want %h", instr, NOPV); else passed++;
    checks++; if (pc !== 32'h0) $display("FAIL post_rst_pc: got %h want 0", pc); else passed++;
  endtask

  // Continues from the first post-reset cycle left by test_reset.
  task automatic test_sequential();
    logic [31:0] exp_req = 32'h4;
    logic [31:0] exp_pc  = 32'h0;
    int got = 0, first_n = -1, last_n = -1;
    for (int n = 1; n <= 40 && got < 12; n++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        checks++; if (mem_addr !== exp_req) $display("FAIL seq_addr: got %h want %h", mem_addr, exp_req); else passed++;
        exp_req += 32'h4;
      end
      if (instr_valid) begin
        if (first_n < 0) first_n = n;
        last_n = n;
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc))
          $display("FAIL seq_instr: got pc %h instr %h want pc %h instr %h", pc, instr, exp_pc, mem_word(exp_pc));
        else passed++;
        exp_pc += 32'h4;
        got++;
      end
    end
    checks++; if (got != 12) $display("FAIL seq_count: got %0d want 12", got); else passed++;
    checks++; if (first_n != 2) $display("FAIL seq_latency: got cycle %0d want 2", first_n); else passed++;
    checks++; if (last_n != 13) $display("FAIL seq_throughput: got cycle %0d want 13", last_n); else passed++;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_req = 32'h0;
    logic [31:0] exp_pc  = 32'h0;
    int acc = 0, got = 0;
    instr_ready = 1'b0; ready_mode = 0; lat_random = 0; lat_fixed = 1;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        checks++; if (mem_addr !== exp_req) $display("FAIL bp_addr: got %h want %h", mem_addr, exp_req); else passed++;
        exp_req += 32'h4;
        acc++;
      end
    end
    checks++; if (acc != 4) $display("FAIL bp_accepted: got %0d want 4", acc); else passed++;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL bp_req_stalled: got %b want 0", mem_req_valid); else passed++;
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h0) $display("FAIL bp_head: got valid %b pc %h want 1 0", instr_valid, pc); else passed++;
    @(posedge clk); #1; instr_ready = 1'b1;
    for (int n = 0; n < 10 && got < 4; n++) begin
      @(negedge clk);
      if (instr_valid) begin
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc))
          $display("FAIL bp_drain: got pc %h instr %h want pc %h", pc, instr, exp_pc);
        else passed++;
        exp_pc += 32'h4;
        got++;
      end
    end
    checks++; if (got != 4) $display("FAIL bp_drain_count: got %0d want 4", got); else passed++;
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] exp_pc = 32'h104;
    int got = 0, first_n = -1;
    instr_ready = 1'b1; ready_mode = 0; lat_random = 0; lat_fixed = 3;
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    pc_src = 1'b1; branch_target = 32'h0000_0105;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL redir_req_blocked: got %b want 0", mem_req_valid); else passed++;
    checks++; if (instr_valid !== 1'b0) $display("FAIL redir_instr_blocked: got %b want 0", instr_valid); else passed++;
    @(posedge clk); #1; pc_src = 1'b0;
    for (int n = 0; n < 30 && got < 3; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checks++;
        if (mem_req_valid !== 1'b1 || mem_addr !== 32'h104)
          $display("FAIL redir_target_addr: got valid %b addr %h want 1 00000104", mem_req_valid, mem_addr);
        else passed++;
      end
      if (instr_valid) begin
        if (first_n < 0) first_n = n;
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc))
          $display("FAIL redir_pc: got pc %h instr %h want pc %h", pc, instr, exp_pc);
        else passed++;
        exp_pc += 32'h4;
        got++;
      end
    end
    checks++; if (first_n != 4) $display("FAIL redir_first_valid: got cycle %0d want 4", first_n); else passed++;
    checks++; if (got != 3) $display("FAIL redir_count: got %0d want 3", got); else passed++;
  endtask

  task automatic test_redirect_with_rsp();
    logic [31:0] exp_pc = 32'h200;
    int got = 0, first_n = -1;
    instr_ready = 1'b1; ready_mode = 0; lat_random = 0; lat_fixed = 1;
    do_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    pc_src = 1'b1; branch_target = 32'h0000_0200;
    @(negedge clk);
    checks++; if (instr_valid !== 1'b0) $display("FAIL rrsp_masked: got %b want 0", instr_valid); else passed++;
    @(posedge clk); #1; pc_src = 1'b0;
    for (int n = 0; n < 30 && got < 3; n++) begin
      @(negedge clk);
      if (instr_valid) begin
        if (first_n < 0) first_n = n;
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc))
          $display("FAIL rrsp_pc: got pc %h instr %h want pc %h", pc, instr, exp_pc);
        else passed++;
        exp_pc += 32'h4;
        got++;
      end
    end
    checks++; if (first_n != 2) $display("FAIL rrsp_first_valid: got cycle %0d want 2", first_n); else passed++;
    checks++; if (got != 3) $display("FAIL rrsp_count: got %0d want 3", got); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc = 32'hFFFF_FFF8;
    int got = 0;
    instr_ready = 1'b1; ready_mode = 0; lat_random = 0; lat_fixed = 1;
    do_reset();
    pc_src = 1'b1; branch_target = 32'hFFFF_FFFB;
    @(negedge clk);
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL wrap_req_blocked: got %b want 0", mem_req_valid); else passed++;
    @(posedge clk); #1; pc_src = 1'b0;
    for (int n = 0; n < 20 && got < 4; n++) begin
      @(negedge clk);
      if (n == 0) begin
        checks++; if (mem_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_addr: got %h want fffffff8", mem_addr); else passed++;
      end
      if (instr_valid) begin
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc))
          $display("FAIL wrap_pc: got pc %h want %h", pc, exp_pc);
        else passed++;
        exp_pc += 32'h4;
        got++;
      end
    end
    checks++; if (got != 4) $display("FAIL wrap_count: got %0d want 4", got); else passed++;
  endtask

  task automatic test_random_stream();
    logic [31:0] exp_pc = RV;
    int got = 0, bad = 0;
    ready_mode = 1; lat_random = 1;
    instr_ready = 1'b0;
    do_reset();
    for (int n = 0; n < 30000 && got < 1000; n++) begin
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (instr_valid && instr_ready) begin
        checks++;
        if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          bad++;
          if (bad <= 5) $display("FAIL rand_pc: got pc %h instr %h want pc %h", pc, instr, exp_pc);
        end else passed++;
        exp_pc += 32'h4;
        got++;
      end
      @(posedge clk); #1;
    end
    checks++; if (got != 1000) $display("FAIL rand_count: got %0d want 1000", got); else passed++;
    ready_mode = 0; lat_random = 0;
  endtask

  task automatic test_reset_midstream();
    instr_ready = 1'b0; ready_mode = 0; lat_random = 0; lat_fixed = 1;
    do_reset();
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++; if (instr_valid !== 1'b1 || pc !== 32'h0) $display("FAIL mid_full_head: got valid %b pc %h want 1 0", instr_valid, pc); else passed++;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL mid_full_stall: got %b want 0", mem_req_valid); else passed++;
    #1; rst_n = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", instr_valid); else passed++;
    checks++; if (pc !== 32'h0) $display("FAIL mid_rst_pc: got %h want 0", pc); else passed++;
    checks++; if (instr !== 32'h0) $display("FAIL mid_rst_instr: got %h want 0", instr); else passed++;
    checks++; if (mem_req_valid !== 1'b0) $display("FAIL mid_rst_req: got %b want 0", mem_req_valid); else passed++;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== RV)
      $display("FAIL mid_rst_restart: got valid %b addr %h want 1 %h", mem_req_valid, mem_addr, RV);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_wrap();
    test_random_stream();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
